// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner.
package keypad_pkg;

    // Widest key code the event record can carry (up to 256 keys).
    localparam int EVT_CODE_MAX_W = 8;

    // Scan phase: columns are held for a settle period, then rows are sampled.
    typedef enum logic {
        SETTLE,
        SAMPLE
    } scan_state_t;

    // One key event as seen by the consumer.
    typedef struct packed {
        logic [EVT_CODE_MAX_W-1:0] code;
        logic                      press;
    } evt_t;

    // Width of an index that counts 0..n-1, never narrower than one bit.
    function automatic int key_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_integrator.sv
// Debounce integrator for a single key: counts consecutive samples that
// disagree with the debounced state and flips the state once the count is
// ripe and the top level grants the flip.
module key_integrator
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_en,
    input  logic sample,
    input  logic grant,
    output logic ripe,
    output logic stable
);

    localparam int            DW      = key_idx_w(DEBOUNCE_COUNT);
    localparam logic [DW-1:0] CNT_MAX = DW'(DEBOUNCE_COUNT - 1);

    logic [DW-1:0] cnt;
    logic          differs;

    assign differs = (sample != stable);

    // A key is ripe when this sample disagrees and the count has saturated.
    assign ripe = sample_en && differs && (cnt == CNT_MAX);

    // Count disagreeing samples; flip only when ripe and granted, otherwise hold.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register, matching the hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sample_en) begin
            if (!differs) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else if (grant) begin
                stable <= ~stable;
                cnt    <= '0;
            end
        end
    end

endmodule

// File: rtl/keypad_scan_debouncer.sv
// Keypad matrix scanner with per-key debouncing and a single-entry event
// slot behind a valid/ready handshake.
// Optional feature macro: KEYPAD_RELEASE_EVT_EN -- when defined, releases
// arbitrate and produce events like presses; otherwise releases update
// key_down silently and evt_press is tied high.
module keypad_scan_debouncer
    import keypad_pkg::*;
#(
    parameter  int ROWS           = 3,
    parameter  int COLS           = 3,
    parameter  int SETTLE_CYCLES  = 4,
    parameter  int DEBOUNCE_COUNT = 3,
    localparam int NKEYS          = ROWS * COLS,
    localparam int KW             = key_idx_w(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic [NKEYS-1:0] key_down,
    output logic             evt_valid,
    output logic [KW-1:0]    evt_code,
    output logic             evt_press,
    input  logic             evt_ready
);

    localparam int CW = key_idx_w(COLS);
    localparam int SW = key_idx_w(SETTLE_CYCLES);

    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    // With a one-cycle settle every cycle is a sample cycle.
    localparam scan_state_t   PHASE_INIT  = (SETTLE_CYCLES == 1) ? SAMPLE : SETTLE;

`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit REL_EVT = 1'b1;
`else
    localparam bit REL_EVT = 1'b0;
`endif

    // Scan state
    scan_state_t   phase;
    logic [CW-1:0] col_idx;
    logic [CW-1:0] col_next;
    logic [SW-1:0] settle_cnt;
    logic          sample_now;

    // Per-key integrator interface
    logic [NKEYS-1:0] ripe;
    logic [NKEYS-1:0] stable;
    logic [NKEYS-1:0] grant;

    // Arbitration
    logic          win_found;
    logic [KW-1:0] win_idx;
    logic          slot_free;
    logic          load;

    assign sample_now = (phase == SAMPLE);
    assign key_down   = stable;

    // Next column index, wrapping after the last column.
    always_comb begin
        col_next = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
    end

    // Scan sequencer: hold each column for SETTLE_CYCLES, advance on the sample cycle.
    // The phase register is set one cycle ahead so the sample cycle is a flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_idx    <= '0;
            settle_cnt <= '0;
            phase      <= PHASE_INIT;
            col        <= ~COLS'(1);
        end else if (phase == SAMPLE) begin
            settle_cnt <= '0;
            phase      <= PHASE_INIT;
            col_idx    <= col_next;
            col        <= ~(COLS'(1) << col_next);
        end else begin
            settle_cnt <= settle_cnt + 1'b1;
            phase      <= (settle_cnt + 1'b1 == SETTLE_LAST) ? SAMPLE : SETTLE;
        end
    end

    // One integrator per key; a key only samples on its own column's sample cycle.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int I = r * COLS + c;

            key_integrator #(
                .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
            ) u_key (
                .clk       (clk),
                .reset     (reset),
                .sample_en (sample_now && (col_idx == CW'(c))),
                .sample    (~row[r]),
                .grant     (grant[I]),
                .ripe      (ripe[I]),
                .stable    (stable[I])
            );
        end
    end

    // The slot can take a new event if empty or being drained this cycle.
    assign slot_free = !evt_valid || evt_ready;

    // Priority grant: lowest ripe key that needs an event wins, if the slot is free.
    // Only the driven column can be ripe, so lowest key index is lowest row.
    // Silent releases (no event) are granted unconditionally.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        grant     = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (ripe[i] && (REL_EVT || !stable[i]) && !win_found) begin
                win_found = 1'b1;
                win_idx   = KW'(i);
            end
        end
        load = win_found && slot_free;
        for (int i = 0; i < NKEYS; i++) begin
            grant[i] = (load && (win_idx == KW'(i))) ||
                       (!REL_EVT && ripe[i] && stable[i]);
        end
    end

    // Event slot: a new load beats a simultaneous handshake; a bare handshake empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_code  <= '0;
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_code  <= win_idx;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

`ifdef KEYPAD_RELEASE_EVT_EN
    // Direction of the loaded event is the winner's state after its flip.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_press <= 1'b0;
        end else if (load) begin
            evt_press <= ~stable[win_idx];
        end
    end
`else
    // Only presses generate events, so the direction is always "press".
    assign evt_press = 1'b1;
`endif

endmodule

// File: tb/tb_keypad_scan_debouncer.sv
// Self-checking bench for keypad_scan_debouncer (3x3, settle 4, debounce 3).
module tb_keypad_scan_debouncer;
    import keypad_pkg::*;

    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int SETTLE = 4;
    localparam int DEB    = 3;
    localparam int NK     = ROWS * COLS;

`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit REL_EVT = 1'b1;
`else
    localparam bit REL_EVT = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [NK-1:0]   key_down;
    logic            evt_valid;
    logic [3:0]      evt_code;
    logic            evt_press;
    logic            evt_ready;

    // Physical switch matrix: pressed[r*COLS+c] closes row r to column c.
    logic [NK-1:0]   pressed;

    int checks = 0;
    int errors = 0;

    keypad_scan_debouncer #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_COUNT (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_down  (key_down),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_press (evt_press),
        .evt_ready (evt_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A row reads low when any pressed key on it sits on a column driven low.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row[r] = ~|(pressed[r*COLS +: COLS] & ~col);
        end
    end

    // Reference model: time since reset decides column and sample instants.
    int   m_t;
    bit   m_stable [NK];
    int   m_cnt    [NK];
    bit   m_valid;
    evt_t m_evt;

    task automatic model_edge();
        int c;
        int win;
        bit smp;
        bit free;
        bit pr;
        if (reset) begin
            m_t     = 0;
            m_valid = 1'b0;
            m_evt   = '0;
            for (int i = 0; i < NK; i++) begin
                m_stable[i] = 1'b0;
                m_cnt[i]    = 0;
            end
            return;
        end
        c    = (m_t / SETTLE) % COLS;
        smp  = (m_t % SETTLE) == SETTLE - 1;
        free = !m_valid || evt_ready;
        win  = -1;
        if (smp) begin
            for (int r = 0; r < ROWS; r++) begin
                int i;
                i  = r * COLS + c;
                pr = pressed[i];
                if (pr == m_stable[i]) begin
                    m_cnt[i] = 0;
                end else if (m_cnt[i] < DEB - 1) begin
                    m_cnt[i] = m_cnt[i] + 1;
                end else if (!REL_EVT && m_stable[i]) begin
                    m_stable[i] = 1'b0;
                    m_cnt[i]    = 0;
                end else if (win < 0) begin
                    win = i;
                end
            end
        end
        if (win >= 0 && free) begin
            m_stable[win] = !m_stable[win];
            m_cnt[win]    = 0;
            m_evt.code    = 8'(win);
            m_evt.press   = m_stable[win];
            m_valid       = 1'b1;
        end else if (m_valid && evt_ready) begin
            m_valid = 1'b0;
        end
        m_t = m_t + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic compare_all();
        logic [COLS-1:0] ec;
        logic [NK-1:0]   ek;
        ec = ~(COLS'(1) << ((m_t / SETTLE) % COLS));
        for (int i = 0; i < NK; i++) ek[i] = m_stable[i];
        check("m_col",       32'(col),       32'(ec));
        check("m_key_down",  32'(key_down),  32'(ek));
        check("m_evt_valid", 32'(evt_valid), 32'(m_valid));
        check("m_evt_code",  32'(evt_code),  32'(m_evt.code[3:0]));
        check("m_evt_press", 32'(evt_press), 32'(REL_EVT ? m_evt.press : 1'b1));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic tick_until(input int target);
        while (m_t < target) tick();
    endtask

    typedef struct {
        logic [NK-1:0]   press_in;
        logic            ready_in;
        int              cycles;
        logic [COLS-1:0] exp_col;
        logic [NK-1:0]   exp_keys;
        logic            exp_valid;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Scan rotation with idle keypad: state after each single cycle.
        tbl[0]  = '{9'h000, 1'b1, 1, 3'b110, 9'h000, 1'b0};
        tbl[1]  = '{9'h000, 1'b1, 1, 3'b110, 9'h000, 1'b0};
        tbl[2]  = '{9'h000, 1'b1, 1, 3'b110, 9'h000, 1'b0};
        tbl[3]  = '{9'h000, 1'b1, 1, 3'b101, 9'h000, 1'b0};
        tbl[4]  = '{9'h000, 1'b1, 1, 3'b101, 9'h000, 1'b0};
        tbl[5]  = '{9'h000, 1'b1, 1, 3'b101, 9'h000, 1'b0};
        tbl[6]  = '{9'h000, 1'b1, 1, 3'b101, 9'h000, 1'b0};
        tbl[7]  = '{9'h000, 1'b1, 1, 3'b011, 9'h000, 1'b0};
        tbl[8]  = '{9'h000, 1'b1, 1, 3'b011, 9'h000, 1'b0};
        tbl[9]  = '{9'h000, 1'b1, 1, 3'b011, 9'h000, 1'b0};
        tbl[10] = '{9'h000, 1'b1, 1, 3'b011, 9'h000, 1'b0};
        tbl[11] = '{9'h000, 1'b1, 1, 3'b110, 9'h000, 1'b0};

        pressed   = '0;
        evt_ready = 1'b1;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_col",       32'(col),       32'(3'b110));
        check("rst_key_down",  32'(key_down),  32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_evt_code",  32'(evt_code),  32'h0);
        check("rst_evt_press", 32'(evt_press), 32'(!REL_EVT));

        // 1. Scan rotation
        for (int k = 0; k < 12; k++) begin
            pressed   = tbl[k].press_in;
            evt_ready = tbl[k].ready_in;
            for (int n = 0; n < tbl[k].cycles; n++) tick();
            check($sformatf("scan_col[%0d]", k),   32'(col),       32'(tbl[k].exp_col));
            check($sformatf("scan_keys[%0d]", k),  32'(key_down),  32'(tbl[k].exp_keys));
            check($sformatf("scan_valid[%0d]", k), 32'(evt_valid), 32'(tbl[k].exp_valid));
        end

        // 2. Single press of key (1,2): column-2 samples at t=23,35,47
        pressed[5] = 1'b1;
        tick_until(47);
        check("press_before_keys", 32'(key_down), 32'h000);
        tick();
        check("press_keys",  32'(key_down),  32'h020);
        check("press_valid", 32'(evt_valid), 32'h1);
        check("press_code",  32'(evt_code),  32'h5);
        check("press_dir",   32'(evt_press), 32'h1);
        tick();
        check("press_drained", 32'(evt_valid), 32'h0);

        // 3. Bounce: key (0,0) seen on two column-0 samples only
        pressed[0] = 1'b1;
        tick_until(64);
        pressed[0] = 1'b0;
        tick_until(96);
        check("bounce_keys",  32'(key_down),  32'h020);
        check("bounce_valid", 32'(evt_valid), 32'h0);

        // 4. Keys 1 and 7 ripen together at t=127
        pressed[1] = 1'b1;
        pressed[7] = 1'b1;
        tick_until(128);
        check("simul_first_code", 32'(evt_code),  32'h1);
        check("simul_first_keys", 32'(key_down),  32'h022);
        tick_until(139);
        check("simul_gap_valid",  32'(evt_valid), 32'h0);
        tick();
        check("simul_second_valid", 32'(evt_valid), 32'h1);
        check("simul_second_code",  32'(evt_code),  32'h7);
        check("simul_second_keys",  32'(key_down),  32'h0A2);

        // 5. Backpressure: release key 5, re-press it with ready low, then key 3
        pressed[5] = 1'b0;
        tick_until(168);
        check("bp_release_keys", 32'(key_down), 32'h082);
        check("bp_release_evt",  32'(evt_valid), 32'(REL_EVT));
        tick();
        evt_ready  = 1'b0;
        pressed[5] = 1'b1;
        tick_until(192);
        pressed[3] = 1'b1;
        tick_until(240);
        check("bp_hold_valid", 32'(evt_valid), 32'h1);
        check("bp_hold_code",  32'(evt_code),  32'h5);
        check("bp_hold_keys",  32'(key_down),  32'h0A2);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("bp_drained", 32'(evt_valid), 32'h0);
        tick_until(244);
        check("bp_next_valid", 32'(evt_valid), 32'h1);
        check("bp_next_code",  32'(evt_code),  32'h3);
        check("bp_next_keys",  32'(key_down),  32'h0AA);
        evt_ready = 1'b1;
        tick();

        // 6. Release key 5, then reset mid-scan with any event left pending
        pressed[5] = 1'b0;
        tick_until(276);
        check("rel_keys",  32'(key_down),  32'h08A);
        check("rel_valid", 32'(evt_valid), 32'(REL_EVT));
        if (REL_EVT) begin
            check("rel_code", 32'(evt_code),  32'h5);
            check("rel_dir",  32'(evt_press), 32'h0);
        end
        evt_ready = 1'b0;
        tick_until(281);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_col",   32'(col),       32'(3'b110));
        check("mid_rst_keys",  32'(key_down),  32'h0);
        check("mid_rst_valid", 32'(evt_valid), 32'h0);
        check("mid_rst_code",  32'(evt_code),  32'h0);
        check("mid_rst_press", 32'(evt_press), 32'(!REL_EVT));

        // Randomized: sparse key patterns held for random spans (short ones
        // act as bounces), random backpressure and occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            pressed = 9'($urandom) & 9'($urandom);
            len     = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                reset     = ($urandom_range(0, 499) == 0);
                tick();
            end
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
